// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: one FSM sequences fetch/decode/execute/memory/writeback over a shared memory port and ALU.
// Latency: beq/j 3, R/sw/ori 4, lw 5 cycles; the FSM holds its memory state for every cycle that mem_ready is low.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_I_EXEC   = 4'd11,
        ST_I_WB     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // ALU computes PC+4 while the instruction word is read
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_R_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ORI:       state_d = ST_I_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                state_d   = ST_R_WB;
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                // Target was left in ALUOut by DECODE; compare rs-rt here
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b011;
                state_d   = ST_I_WB;
            end
            ST_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, instr_done};
    end

    assign retired_cnt = retired_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/controls queued with stimulus, checked in each scenario.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic        instr_done, illegal_op;
    logic [31:0] retired_cnt;
    logic [3:0]  state;

    logic        pc_write_4, pc_write_cond_4, iord_4, mem_read_4, mem_write_4, ir_write_4;
    logic        reg_dst_4, mem_to_reg_4, reg_write_4, alu_src_a_4;
    logic [1:0]  alu_src_b_4, pc_source_4;
    logic [2:0]  alu_op_4;
    logic        instr_done_4, illegal_op_4;
    logic [3:0]  retired_cnt_4;
    logic [3:0]  state_4;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7;
    localparam logic [3:0] S_R_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_I_EXEC = 4'd11, S_I_WB = 4'd12;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .retired_cnt(retired_cnt), .state(state)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write_4), .pc_write_cond(pc_write_cond_4), .iord(iord_4),
        .mem_read(mem_read_4), .mem_write(mem_write_4), .ir_write(ir_write_4),
        .reg_dst(reg_dst_4), .mem_to_reg(mem_to_reg_4), .reg_write(reg_write_4),
        .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4), .alu_op(alu_op_4),
        .pc_source(pc_source_4), .instr_done(instr_done_4), .illegal_op(illegal_op_4),
        .retired_cnt(retired_cnt_4), .state(state_4)
    );

    always #5 clk = ~clk;

    logic [16:0] ctrl, ctrl4;
    assign ctrl  = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    assign ctrl4 = {pc_write_4, pc_write_cond_4, iord_4, mem_read_4, mem_write_4, ir_write_4, reg_dst_4,
                    mem_to_reg_4, reg_write_4, alu_src_a_4, alu_src_b_4, alu_op_4, pc_source_4};

    // Control word each state must drive, written from the state table
    function automatic logic [16:0] spec_ctrl(input logic [3:0] st, input logic mr);
        logic pcw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, psrc;
        logic [2:0] aop;
        {pcw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
        asb = 2'b00; psrc = 2'b00; aop = 3'b000;
        case (st)
            S_FETCH:    begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE:   asb = 2'b11;
            S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            S_MEM_RD:   begin io = 1; mrd = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin io = 1; mwr = 1; end
            S_R_EXEC:   begin asa = 1; aop = 3'b010; end
            S_R_WB:     begin rdst = 1; rw = 1; end
            S_BRANCH:   begin asa = 1; aop = 3'b001; pwc = 1; psrc = 2'b01; end
            S_JUMP:     begin pcw = 1; psrc = 2'b10; end
            S_I_EXEC:   begin asa = 1; asb = 2'b10; aop = 3'b011; end
            S_I_WB:     rw = 1;
            default:    ;
        endcase
        return {pcw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic        done;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_cnt = 0;

    task automatic push(input logic [5:0] op, input logic mr, input logic [3:0] st,
                        input logic done, input logic ill);
        exp_t e;
        e.op = op; e.mr = mr; e.st = st; e.done = done; e.ill = ill; e.cnt = model_cnt;
        sb.push_back(e);
        if (done) model_cnt = model_cnt + 1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state, S_IDLE); end
        checks++; if (ctrl !== 17'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
        checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retired_cnt); end
        mem_ready = 1'b1; #1;
        checks++; if ({ctrl, instr_done, illegal_op} !== 19'd0) begin errors++; $display("FAIL reset_ignore_ready got %h want 0", {ctrl, instr_done, illegal_op}); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (state !== S_IDLE || ctrl !== 17'd0) begin errors++; $display("FAIL idle_after_release state %0d ctrl %h want 0/0", state, ctrl); end
        model_cnt = 0;
    endtask

    task automatic test_rtype();
        push(6'b000000, 1, S_FETCH, 0, 0);
        push(6'b000000, 1, S_DECODE, 0, 0);
        push(6'b000000, 1, S_R_EXEC, 0, 0);
        push(6'b000000, 1, S_R_WB, 1, 0);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            @(negedge clk); opcode = e.op; mem_ready = e.mr; #1;
            checks++; if (state !== e.st) begin errors++; $display("FAIL rtype_state got %0d want %0d", state, e.st); end
            checks++; if (ctrl !== spec_ctrl(e.st, e.mr)) begin errors++; $display("FAIL rtype_ctrl st %0d got %h want %h", e.st, ctrl, spec_ctrl(e.st, e.mr)); end
            checks++; if ({instr_done, illegal_op} !== {e.done, e.ill}) begin errors++; $display("FAIL rtype_pulse got %b want %b", {instr_done, illegal_op}, {e.done, e.ill}); end
            checks++; if (retired_cnt !== e.cnt) begin errors++; $display("FAIL rtype_cnt got %0d want %0d", retired_cnt, e.cnt); end
        end
    endtask

    task automatic test_lw_waits();
        push(6'b100011, 0, S_FETCH, 0, 0);
        push(6'b100011, 0, S_FETCH, 0, 0);
        push(6'b100011, 1, S_FETCH, 0, 0);
        push(6'b100011, 1, S_DECODE, 0, 0);
        push(6'b100011, 0, S_MEM_ADDR, 0, 0);
        push(6'b100011, 0, S_MEM_RD, 0, 0);
        push(6'b100011, 0, S_MEM_RD, 0, 0);
        push(6'b100011, 1, S_MEM_RD, 0, 0);
        push(6'b100011, 0, S_MEM_WB, 1, 0);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            @(negedge clk); opcode = e.op; mem_ready = e.mr; #1;
            checks++; if (state !== e.st) begin errors++; $display("FAIL lw_state got %0d want %0d", state, e.st); end
            checks++; if (ctrl !== spec_ctrl(e.st, e.mr)) begin errors++; $display("FAIL lw_ctrl st %0d got %h want %h", e.st, ctrl, spec_ctrl(e.st, e.mr)); end
            checks++; if ({instr_done, illegal_op} !== {e.done, e.ill}) begin errors++; $display("FAIL lw_pulse got %b want %b", {instr_done, illegal_op}, {e.done, e.ill}); end
            checks++; if (retired_cnt !== e.cnt) begin errors++; $display("FAIL lw_cnt got %0d want %0d", retired_cnt, e.cnt); end
        end
    endtask

    task automatic test_sw_beq_j();
        push(6'b101011, 1, S_FETCH, 0, 0);
        push(6'b101011, 1, S_DECODE, 0, 0);
        push(6'b101011, 1, S_MEM_ADDR, 0, 0);
        push(6'b101011, 0, S_MEM_WR, 0, 0);
        push(6'b101011, 0, S_MEM_WR, 0, 0);
        push(6'b101011, 1, S_MEM_WR, 1, 0);
        push(6'b000100, 1, S_FETCH, 0, 0);
        push(6'b000100, 0, S_DECODE, 0, 0);
        push(6'b000100, 0, S_BRANCH, 1, 0);
        push(6'b000010, 1, S_FETCH, 0, 0);
        push(6'b000010, 0, S_DECODE, 0, 0);
        push(6'b000010, 1, S_JUMP, 1, 0);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            @(negedge clk); opcode = e.op; mem_ready = e.mr; #1;
            checks++; if (state !== e.st) begin errors++; $display("FAIL swbj_state got %0d want %0d", state, e.st); end
            checks++; if (ctrl !== spec_ctrl(e.st, e.mr)) begin errors++; $display("FAIL swbj_ctrl st %0d got %h want %h", e.st, ctrl, spec_ctrl(e.st, e.mr)); end
            checks++; if ({instr_done, illegal_op} !== {e.done, e.ill}) begin errors++; $display("FAIL swbj_pulse got %b want %b", {instr_done, illegal_op}, {e.done, e.ill}); end
            checks++; if (retired_cnt !== e.cnt) begin errors++; $display("FAIL swbj_cnt got %0d want %0d", retired_cnt, e.cnt); end
        end
    endtask

    task automatic test_illegal();
        push(6'b111111, 1, S_FETCH, 0, 0);
        push(6'b111111, 1, S_DECODE, 0, 1);
        push(6'b111111, 0, S_FETCH, 0, 0);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            @(negedge clk); opcode = e.op; mem_ready = e.mr; #1;
            checks++; if (state !== e.st) begin errors++; $display("FAIL illegal_state got %0d want %0d", state, e.st); end
            checks++; if (ctrl !== spec_ctrl(e.st, e.mr)) begin errors++; $display("FAIL illegal_ctrl st %0d got %h want %h", e.st, ctrl, spec_ctrl(e.st, e.mr)); end
            checks++; if ({instr_done, illegal_op} !== {e.done, e.ill}) begin errors++; $display("FAIL illegal_pulse got %b want %b", {instr_done, illegal_op}, {e.done, e.ill}); end
            checks++; if (retired_cnt !== e.cnt) begin errors++; $display("FAIL illegal_cnt got %0d want %0d", retired_cnt, e.cnt); end
        end
    endtask

    task automatic test_reset_mid_mem();
        push(6'b101011, 1, S_FETCH, 0, 0);
        push(6'b101011, 1, S_DECODE, 0, 0);
        push(6'b101011, 1, S_MEM_ADDR, 0, 0);
        push(6'b101011, 0, S_MEM_WR, 0, 0);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            @(negedge clk); opcode = e.op; mem_ready = e.mr; #1;
            checks++; if (state !== e.st) begin errors++; $display("FAIL midrst_state got %0d want %0d", state, e.st); end
            checks++; if (ctrl !== spec_ctrl(e.st, e.mr)) begin errors++; $display("FAIL midrst_ctrl st %0d got %h want %h", e.st, ctrl, spec_ctrl(e.st, e.mr)); end
            checks++; if (retired_cnt !== e.cnt) begin errors++; $display("FAIL midrst_cnt got %0d want %0d", retired_cnt, e.cnt); end
        end
        rst = 1'b1; #1;
        model_cnt = 0;
        checks++; if (mem_write !== 1'b0 || state !== S_IDLE) begin errors++; $display("FAIL midrst_drop mem_write %b state %0d want 0/0", mem_write, state); end
        checks++; if ({instr_done, ctrl} !== 18'd0) begin errors++; $display("FAIL midrst_outputs got %h want 0", {instr_done, ctrl}); end
        checks++; if (retired_cnt !== model_cnt || retired_cnt_4 !== model_cnt[3:0]) begin errors++; $display("FAIL midrst_cnt_clear got %0d/%0d want 0", retired_cnt, retired_cnt_4); end
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL midrst_idle got %0d want %0d", state, S_IDLE); end
    endtask

    task automatic test_ori_wrap();
        for (int n = 0; n < 17; n++) begin
            push(6'b001101, 1, S_FETCH, 0, 0);
            push(6'b001101, 1, S_DECODE, 0, 0);
            push(6'b001101, 0, S_I_EXEC, 0, 0);
            push(6'b001101, 1, S_I_WB, 1, 0);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            @(negedge clk); opcode = e.op; mem_ready = e.mr; #1;
            checks++; if (state !== e.st || state_4 !== e.st) begin errors++; $display("FAIL ori_state got %0d/%0d want %0d", state, state_4, e.st); end
            checks++; if (ctrl !== spec_ctrl(e.st, e.mr) || ctrl4 !== spec_ctrl(e.st, e.mr)) begin errors++; $display("FAIL ori_ctrl st %0d got %h/%h want %h", e.st, ctrl, ctrl4, spec_ctrl(e.st, e.mr)); end
            checks++; if ({instr_done, illegal_op, instr_done_4, illegal_op_4} !== {e.done, e.ill, e.done, e.ill}) begin errors++; $display("FAIL ori_pulse got %b want %b", {instr_done, illegal_op, instr_done_4, illegal_op_4}, {e.done, e.ill, e.done, e.ill}); end
            checks++; if (retired_cnt !== e.cnt || retired_cnt_4 !== e.cnt[3:0]) begin errors++; $display("FAIL ori_cnt got %0d/%0d want %0d", retired_cnt, retired_cnt_4, e.cnt); end
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++; if (retired_cnt !== 32'd17) begin errors++; $display("FAIL ori_total got %0d want 17", retired_cnt); end
        checks++; if (retired_cnt_4 !== 4'd1) begin errors++; $display("FAIL ori_wrap got %0d want 1", retired_cnt_4); end
        checks++; if (state !== S_FETCH) begin errors++; $display("FAIL ori_next got %0d want %0d", state, S_FETCH); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_waits();
        test_sw_beq_j();
        test_illegal();
        test_reset_mid_mem();
        test_ori_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
